alu_exec_unit: RTL and testbench
================================

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving operand/result width (legal: 32, 64).
REQ-002 The block SHALL have parameter ITER_BITS, default 1, giving quotient/multiplier bits retired per iterative cycle (legal: 1, 2, 4; must divide XLEN).
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  unit can accept a request this cycle.
REQ-007 opcode  input  7  RV opcode field.
REQ-008 funct3  input  3  RV funct3 field.
REQ-009 funct7  input  7  RV funct7 field.
REQ-010 op_a  input  XLEN  first operand.
REQ-011 op_b  input  XLEN  second operand (register or immediate).
REQ-012 out_valid  output  1  result present.
REQ-013 out_ready  input  1  consumer accepts result.
REQ-014 result  output  XLEN  computed value; branch ops yield 1/0.
REQ-015 illegal  output  1  qualifies result; set for undecodable opcode/funct combinations.

Function
REQ-016 Request SHALL be accepted when in_valid && in_ready; all inputs are sampled only on that cycle.
REQ-017 Decode SHALL cover LOAD/STORE/AUIPC (add), LUI (result = op_b), BRANCH (SEQ/SNE/SLT/SGE/SLTU/SGEU), OP/OP_IMM (ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND), SUB only for OP with funct7[5]=1.
REQ-018 Shift amount SHALL be op_b[$clog2(XLEN)-1:0]; all add/sub wrap modulo 2^XLEN.
REQ-019 FSM states SHALL be IDLE, BUSY, DONE; in_ready = 1 only in IDLE.
REQ-020 IDLE: accept of single-cycle op -> DONE with result registered; out_valid asserts the next cycle (latency 1).
REQ-021 IDLE: accept of MUL/DIV-class op -> BUSY; BUSY runs XLEN/ITER_BITS iterations then -> DONE (latency XLEN/ITER_BITS + 1).
REQ-022 DONE: out_valid = 1; result/illegal held stable until out_valid && out_ready, then -> IDLE; no new accept in that cycle.
REQ-023 Undecodable opcode or funct3/funct7 SHALL complete with latency 1, illegal = 1, result = 0; no simulation-time messages.
REQ-024 MUL SHALL return low XLEN bits; MULH/MULHSU/MULHU return high XLEN bits with signed x signed, signed x unsigned, unsigned x unsigned operands.
REQ-025 DIV/DIVU by zero SHALL return all-ones; REM/REMU by zero return op_a.
REQ-026 DIV of -2^(XLEN-1) by -1 SHALL return op_a; REM returns 0.
REQ-027 Signed divide results SHALL truncate toward zero; remainder takes the sign of op_a.

Reset
REQ-028 rst SHALL force IDLE in the same clock edge, aborting any BUSY/DONE operation without output.
REQ-029 After reset: in_ready = 1, out_valid = 0, result = 0, illegal = 0, iteration counter = 0.

Configuration
REQ-030 Macro ALU_MULDIV_EN defined: OP opcode with funct7 = 0000001 decodes as RV M-extension (MUL..REMU) via BUSY path.
REQ-031 Macro ALU_MULDIV_EN undefined: no multiplier/divider datapath or BUSY state logic is built; funct7 = 0000001 completes as illegal per REQ-023.

Structure
REQ-032 Shared package alu_pkg SHALL hold the ALU control enum (existing ops plus MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU), FSM state enum, and opcode/funct3 constants.
REQ-033 Decode SHALL live in one combinational sub-module alu_op_decode (opcode/funct3/funct7 -> control + illegal + is_multicycle); iterative datapath stays in alu_exec_unit.

Verification
REQ-034 OP ADD, op_a=5, op_b=0xFFFFFFFF, out_ready=1 -> out_valid cycle after accept, result=4, illegal=0.
REQ-035 BRANCH BLT, op_a=0xFFFFFFFF, op_b=1 -> result=1; BLTU same operands -> result=0.
REQ-036 ALU_MULDIV_EN, XLEN=32, ITER_BITS=1: DIV op_a=-7, op_b=2 -> result=-3 after 33 cycles; REM -> -1; DIV by 0 -> 0xFFFFFFFF.
REQ-037 MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; DIV 0x80000000 / -1 -> 0x80000000; in_ready=0 throughout BUSY.
REQ-038 out_ready held 0 for 5 cycles in DONE -> result stable, in_ready=0; rst asserted mid-BUSY -> next cycle in_ready=1, out_valid=0.
REQ-039 Macro undefined: OP funct7=0000001 funct3=000 -> latency 1, illegal=1, result=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execution unit slice.
//   - RV opcode / funct3 / funct7 field constants
//   - alu_op_e : ALU control encoding (base ops, branch compares, M-extension)
//   - state_e  : execution FSM states (fixed legacy encodings)
// Optional feature macro: ALU_MULDIV_EN (see alu_exec_unit / alu_op_decode).
package alu_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [4:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
    ALU_OR, ALU_AND, ALU_PASSB, ALU_SEQ, ALU_SNE, ALU_SGE, ALU_SGEU,
    ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
    ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
  } alu_op_e;

  // Encodings kept identical to the legacy state constants.
  localparam logic [1:0] ST_IDLE_ENC = 2'd0;
  localparam logic [1:0] ST_BUSY_ENC = 2'd1;
  localparam logic [1:0] ST_DONE_ENC = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = ST_IDLE_ENC,
    ST_BUSY = ST_BUSY_ENC,
    ST_DONE = ST_DONE_ENC
  } state_e;

  function automatic logic is_mul_op(input alu_op_e op);
    return op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU};
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational instruction-field decoder for alu_exec_unit.
// Ports:
//   opcode_i, funct3_i, funct7_i : RV instruction fields
//   ctrl_o                       : ALU control (ALU_ADD when illegal)
//   illegal_o                    : undecodable opcode/funct combination
//   is_multicycle_o              : op needs the iterative mul/div path
// Macro ALU_MULDIV_EN: when defined, OP with funct7=0000001 decodes as RV-M.
module alu_op_decode
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  output alu_op_e    ctrl_o,
  output logic       illegal_o,
  output logic       is_multicycle_o
);

  // OP-IMM shifts: funct7 is the upper immediate; bit 5 selects arithmetic,
  // bit 0 is shamt[5] and only legal on a 64-bit datapath.
  logic imm_sh_ok;
  assign imm_sh_ok = (funct7_i[6] == 1'b0) && (funct7_i[4:1] == 4'b0000) &&
                     (!funct7_i[0] || (XLEN == 64));

  always_comb begin
    ctrl_o          = ALU_ADD;
    illegal_o       = 1'b0;
    is_multicycle_o = 1'b0;
    case (opcode_i)
      OPC_LOAD, OPC_STORE, OPC_AUIPC: ctrl_o = ALU_ADD;
      OPC_LUI: ctrl_o = ALU_PASSB;
      OPC_BRANCH: begin
        case (funct3_i)
          F3_BEQ:  ctrl_o = ALU_SEQ;
          F3_BNE:  ctrl_o = ALU_SNE;
          F3_BLT:  ctrl_o = ALU_SLT;
          F3_BGE:  ctrl_o = ALU_SGE;
          F3_BLTU: ctrl_o = ALU_SLTU;
          F3_BGEU: ctrl_o = ALU_SGEU;
          default: illegal_o = 1'b1;
        endcase
      end
      OPC_OP_IMM: begin
        case (funct3_i)
          F3_ADD:  ctrl_o = ALU_ADD;
          F3_SLT:  ctrl_o = ALU_SLT;
          F3_SLTU: ctrl_o = ALU_SLTU;
          F3_XOR:  ctrl_o = ALU_XOR;
          F3_OR:   ctrl_o = ALU_OR;
          F3_AND:  ctrl_o = ALU_AND;
          F3_SLL: begin
            if (imm_sh_ok && !funct7_i[5]) ctrl_o = ALU_SLL;
            else                           illegal_o = 1'b1;
          end
          default: begin  // F3_SR
            if (imm_sh_ok) ctrl_o = funct7_i[5] ? ALU_SRA : ALU_SRL;
            else           illegal_o = 1'b1;
          end
        endcase
      end
      OPC_OP: begin
        if (funct7_i == F7_BASE) begin
          case (funct3_i)
            F3_ADD:  ctrl_o = ALU_ADD;
            F3_SLL:  ctrl_o = ALU_SLL;
            F3_SLT:  ctrl_o = ALU_SLT;
            F3_SLTU: ctrl_o = ALU_SLTU;
            F3_XOR:  ctrl_o = ALU_XOR;
            F3_SR:   ctrl_o = ALU_SRL;
            F3_OR:   ctrl_o = ALU_OR;
            default: ctrl_o = ALU_AND;
          endcase
        end else if (funct7_i == F7_ALT) begin
          case (funct3_i)
            F3_ADD:  ctrl_o = ALU_SUB;
            F3_SR:   ctrl_o = ALU_SRA;
            default: illegal_o = 1'b1;
          endcase
`ifdef ALU_MULDIV_EN
        end else if (funct7_i == F7_MULDIV) begin
          is_multicycle_o = 1'b1;
          case (funct3_i)
            F3_MUL:    ctrl_o = ALU_MUL;
            F3_MULH:   ctrl_o = ALU_MULH;
            F3_MULHSU: ctrl_o = ALU_MULHSU;
            F3_MULHU:  ctrl_o = ALU_MULHU;
            F3_DIV:    ctrl_o = ALU_DIV;
            F3_DIVU:   ctrl_o = ALU_DIVU;
            F3_REM:    ctrl_o = ALU_REM;
            default:   ctrl_o = ALU_REMU;
          endcase
`endif
        end else begin
          illegal_o = 1'b1;
        end
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit: accepts one decoded RV ALU/branch/address request,
// returns one result through a valid/ready handshake.
// Ports:
//   clk, rst                   : clock, synchronous active-high reset
//   in_valid / in_ready        : request handshake (ready only when idle)
//   opcode, funct3, funct7     : RV instruction fields
//   op_a, op_b                 : operands (XLEN bits)
//   out_valid / out_ready      : result handshake
//   result, illegal            : result (branches give 1/0), illegal flag
// Single-cycle ops: latency 1. With macro ALU_MULDIV_EN defined, RV-M ops
// run on an iterative shift-add / restoring-divide datapath retiring
// ITER_BITS bits per cycle (latency XLEN/ITER_BITS + 1).
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned ITER_BITS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            illegal
);

  localparam int unsigned SHW = $clog2(XLEN);

  state_e          state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            illegal_q, illegal_d;

  alu_op_e dec_ctrl;
  logic    dec_illegal, dec_multi, dec_bad;

  alu_op_decode #(.XLEN(XLEN)) u_decode (
    .opcode_i        (opcode),
    .funct3_i        (funct3),
    .funct7_i        (funct7),
    .ctrl_o          (dec_ctrl),
    .illegal_o       (dec_illegal),
    .is_multicycle_o (dec_multi)
  );

`ifdef ALU_MULDIV_EN
  assign dec_bad = dec_illegal;
`else
  // No iterative datapath exists, so a multicycle decode cannot complete.
  assign dec_bad = dec_illegal | dec_multi;
`endif

  // Single-cycle datapath
  logic [SHW-1:0]  shamt;
  logic            slt, sltu, eq;
  logic [XLEN-1:0] alu_res;

  assign shamt = op_b[SHW-1:0];
  assign slt   = $signed(op_a) < $signed(op_b);
  assign sltu  = op_a < op_b;
  assign eq    = op_a == op_b;

  always_comb begin
    alu_res = '0;
    case (dec_ctrl)
      ALU_ADD:   alu_res = op_a + op_b;
      ALU_SUB:   alu_res = op_a - op_b;
      ALU_SLL:   alu_res = op_a << shamt;
      ALU_SLT:   alu_res = XLEN'(slt);
      ALU_SLTU:  alu_res = XLEN'(sltu);
      ALU_XOR:   alu_res = op_a ^ op_b;
      ALU_SRL:   alu_res = op_a >> shamt;
      ALU_SRA:   alu_res = $unsigned($signed(op_a) >>> shamt);
      ALU_OR:    alu_res = op_a | op_b;
      ALU_AND:   alu_res = op_a & op_b;
      ALU_PASSB: alu_res = op_b;
      ALU_SEQ:   alu_res = XLEN'(eq);
      ALU_SNE:   alu_res = XLEN'(!eq);
      ALU_SGE:   alu_res = XLEN'(!slt);
      ALU_SGEU:  alu_res = XLEN'(!sltu);
      default:   alu_res = '0;
    endcase
  end

`ifdef ALU_MULDIV_EN
  localparam int unsigned NITER = XLEN / ITER_BITS;
  localparam int unsigned CNT_W = $clog2(NITER);

  // Operands are stored as magnitudes; signs are reapplied on the last step.
  // acc holds the product high half / partial remainder, mq the multiplier
  // (shifted out LSB-first) or dividend (shifted out MSB-first, quotient in).
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  acc_q, acc_d, mq_q, mq_d, mcand_q, mcand_d, a_q, a_d;
  alu_op_e          op_q, op_d;
  logic             sa_q, sa_d, sb_q, sb_d, dz_q, dz_d;

  logic sa_start, sb_start;
  assign sa_start = op_a[XLEN-1] & (dec_ctrl inside {ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM});
  assign sb_start = op_b[XLEN-1] & (dec_ctrl inside {ALU_MULH, ALU_DIV, ALU_REM});

  logic [XLEN-1:0] it_acc, it_mq;
  logic [XLEN:0]   sum, shifted, diff;

  always_comb begin
    it_acc  = acc_q;
    it_mq   = mq_q;
    sum     = '0;
    shifted = '0;
    diff    = '0;
    for (int unsigned i = 0; i < ITER_BITS; i++) begin
      if (is_mul_op(op_q)) begin
        sum    = {1'b0, it_acc} + {1'b0, mcand_q & {XLEN{it_mq[0]}}};
        it_mq  = {sum[0], it_mq[XLEN-1:1]};
        it_acc = sum[XLEN:1];
      end else begin
        shifted = {it_acc, it_mq[XLEN-1]};
        diff    = shifted - {1'b0, mcand_q};
        if (shifted >= {1'b0, mcand_q}) begin
          it_acc = diff[XLEN-1:0];
          it_mq  = {it_mq[XLEN-2:0], 1'b1};
        end else begin
          it_acc = shifted[XLEN-1:0];
          it_mq  = {it_mq[XLEN-2:0], 1'b0};
        end
      end
    end
  end

  // Finalisation is fused with the last iteration to hold latency at N+1.
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   quot, remd, md_res;

  always_comb begin
    prod   = {it_acc, it_mq};
    prod_s = (sa_q ^ sb_q) ? -prod : prod;
    quot   = (sa_q ^ sb_q) ? -it_mq : it_mq;
    remd   = sa_q ? -it_acc : it_acc;
    case (op_q)
      ALU_MUL:                        md_res = prod_s[XLEN-1:0];
      ALU_MULH, ALU_MULHSU, ALU_MULHU: md_res = prod_s[2*XLEN-1:XLEN];
      ALU_DIV, ALU_DIVU:              md_res = dz_q ? '1 : quot;
      ALU_REM, ALU_REMU:              md_res = dz_q ? a_q : remd;
      default:                        md_res = '0;
    endcase
  end
`endif

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    illegal_d = illegal_q;
`ifdef ALU_MULDIV_EN
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mq_d    = mq_q;
    mcand_d = mcand_q;
    a_d     = a_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    dz_d    = dz_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
`ifdef ALU_MULDIV_EN
          if (dec_multi && !dec_illegal) begin
            state_d = ST_BUSY;
            cnt_d   = '0;
            acc_d   = '0;
            mq_d    = sa_start ? -op_a : op_a;
            mcand_d = sb_start ? -op_b : op_b;
            a_d     = op_a;
            op_d    = dec_ctrl;
            sa_d    = sa_start;
            sb_d    = sb_start;
            dz_d    = (op_b == '0);
          end else
`endif
          begin
            state_d   = ST_DONE;
            illegal_d = dec_bad;
            result_d  = dec_bad ? '0 : alu_res;
          end
        end
      end
`ifdef ALU_MULDIV_EN
      ST_BUSY: begin
        acc_d = it_acc;
        mq_d  = it_mq;
        if (cnt_q == CNT_W'(NITER - 1)) begin
          state_d   = ST_DONE;
          result_d  = md_res;
          illegal_d = 1'b0;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      result_q  <= '0;
      illegal_q <= 1'b0;
`ifdef ALU_MULDIV_EN
      cnt_q   <= '0;
      acc_q   <= '0;
      mq_q    <= '0;
      mcand_q <= '0;
      a_q     <= '0;
      op_q    <= ALU_ADD;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      dz_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      illegal_q <= illegal_d;
`ifdef ALU_MULDIV_EN
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mq_q    <= mq_d;
      mcand_q <= mcand_d;
      a_q     <= a_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      dz_q    <= dz_d;
`endif
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit (XLEN=32, ITER_BITS=1).
// The RV-M section is compiled when ALU_MULDIV_EN is defined; otherwise the
// bench checks that funct7=0000001 completes as illegal.
module tb_alu_exec_unit;

  localparam int unsigned XLEN = 32;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OPIMM  = 7'b0010011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] F7B    = 7'b0000000;
  localparam logic [6:0] F7A    = 7'b0100000;
  localparam logic [6:0] F7M    = 7'b0000001;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [6:0]      opcode = '0;
  logic [2:0]      funct3 = '0;
  logic [6:0]      funct7 = '0;
  logic [XLEN-1:0] op_a = '0;
  logic [XLEN-1:0] op_b = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [XLEN-1:0] result;
  logic            illegal;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_exec_unit #(.XLEN(XLEN), .ITER_BITS(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .funct3    (funct3),
    .funct7    (funct7),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .illegal   (illegal)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one request and let it be accepted; operands are scrambled
  // afterwards so a unit that re-samples them would be caught.
  task automatic start_op(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                          input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    @(negedge clk);
    in_valid = 1'b1;
    opcode   = opc;
    funct3   = f3;
    funct7   = f7;
    op_a     = a;
    op_b     = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op_a     = ~a;
    op_b     = ~b;
  endtask

  // Latency counts cycles after the accept edge until out_valid is seen.
  task automatic wait_done(output int lat, output bit rdy_seen);
    lat      = 0;
    rdy_seen = 1'b0;
    while (lat < 200) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
      if (in_ready) rdy_seen = 1'b1;
    end
    if (!out_valid) check_eq("timeout_out_valid", 64'(out_valid), 64'd1);
  endtask

  task automatic release_op();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic do_op(input string tag, input logic [6:0] opc, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [XLEN-1:0] exp_res, input logic exp_ill, input int exp_lat);
    int lat;
    bit rdy_seen;
    start_op(opc, f3, f7, a, b);
    wait_done(lat, rdy_seen);
    check_eq({tag, "_res"}, 64'(result), 64'(exp_res));
    check_eq({tag, "_ill"}, 64'(illegal), 64'(exp_ill));
    check_eq({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    if (exp_lat > 1) check_eq({tag, "_rdy_busy"}, 64'(rdy_seen), 64'd0);
    release_op();
  endtask

  initial begin
    int lat;
    bit rdy_seen;
    int seen_valid;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_result", 64'(result), 64'd0);
    check_eq("rst_illegal", 64'(illegal), 64'd0);

    // Base integer ops, latency 1
    do_op("add_wrap", OP, 3'b000, F7B, 32'd5, 32'hFFFF_FFFF, 32'd4, 1'b0, 1);
    do_op("sub", OP, 3'b000, F7A, 32'd10, 32'd3, 32'd7, 1'b0, 1);
    do_op("addi_f7alt", OPIMM, 3'b000, F7A, 32'd10, 32'd3, 32'd13, 1'b0, 1);
    do_op("sub_wrap", OP, 3'b000, F7A, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0, 1);
    do_op("sra_shamt", OP, 3'b101, F7A, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 1'b0, 1);
    do_op("srl", OP, 3'b101, F7B, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0, 1);
    do_op("sll31", OP, 3'b001, F7B, 32'd1, 32'd31, 32'h8000_0000, 1'b0, 1);
    do_op("srai", OPIMM, 3'b101, F7A, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 1);
    do_op("slt", OP, 3'b010, F7B, 32'hFFFF_FFFE, 32'd1, 32'd1, 1'b0, 1);
    do_op("sltu", OP, 3'b011, F7B, 32'hFFFF_FFFE, 32'd1, 32'd0, 1'b0, 1);
    do_op("xor", OP, 3'b100, F7B, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFF00_EDCB, 1'b0, 1);
    do_op("andi", OPIMM, 3'b111, F7B, 32'hF0F0_1234, 32'h0000_0FF0, 32'h0000_0230, 1'b0, 1);
    do_op("ori", OPIMM, 3'b110, F7B, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 1'b0, 1);
    do_op("lui", LUI, 3'b000, F7B, 32'h1234_5678, 32'hABCD_E000, 32'hABCD_E000, 1'b0, 1);
    do_op("auipc", AUIPC, 3'b000, F7B, 32'h0000_1000, 32'h0000_0234, 32'h0000_1234, 1'b0, 1);

    // Branch compares
    do_op("blt", BRANCH, 3'b100, F7B, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1);
    do_op("bltu", BRANCH, 3'b110, F7B, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1);
    do_op("bge", BRANCH, 3'b101, F7B, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1);
    do_op("bgeu", BRANCH, 3'b111, F7B, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1);
    do_op("beq", BRANCH, 3'b000, F7B, 32'd5, 32'd5, 32'd1, 1'b0, 1);
    do_op("bne", BRANCH, 3'b001, F7B, 32'd5, 32'd5, 32'd0, 1'b0, 1);

    // Undecodable combinations
    do_op("ill_opc", 7'b1111111, 3'b000, F7B, 32'd5, 32'd6, 32'd0, 1'b1, 1);
    do_op("ill_op_f7alt", OP, 3'b001, F7A, 32'd5, 32'd6, 32'd0, 1'b1, 1);
    do_op("ill_br_f3", BRANCH, 3'b010, F7B, 32'd5, 32'd6, 32'd0, 1'b1, 1);
    do_op("ill_slli_f7", OPIMM, 3'b001, F7A, 32'd5, 32'd1, 32'd0, 1'b1, 1);

    // Result held while the consumer stalls in DONE
    start_op(OP, 3'b000, F7B, 32'd100, 32'd23);
    wait_done(lat, rdy_seen);
    for (int i = 0; i < 5; i++) begin
      check_eq("hold_result", 64'(result), 64'd123);
      check_eq("hold_in_ready", 64'(in_ready), 64'd0);
      check_eq("hold_out_valid", 64'(out_valid), 64'd1);
      @(negedge clk);
    end
    release_op();
    @(negedge clk);
    check_eq("after_release_in_ready", 64'(in_ready), 64'd1);
    check_eq("after_release_out_valid", 64'(out_valid), 64'd0);

`ifdef ALU_MULDIV_EN
    do_op("div", OP, 3'b100, F7M, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 33);
    do_op("rem", OP, 3'b110, F7M, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 33);
    do_op("div_zero", OP, 3'b100, F7M, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 1'b0, 33);
    do_op("divu_zero", OP, 3'b101, F7M, 32'd7, 32'd0, 32'hFFFF_FFFF, 1'b0, 33);
    do_op("rem_zero", OP, 3'b110, F7M, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 1'b0, 33);
    do_op("remu_zero", OP, 3'b111, F7M, 32'd7, 32'd0, 32'd7, 1'b0, 33);
    do_op("div_ovf", OP, 3'b100, F7M, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 33);
    do_op("rem_ovf", OP, 3'b110, F7M, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 33);
    do_op("divu", OP, 3'b101, F7M, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 1'b0, 33);
    do_op("rem_negb", OP, 3'b110, F7M, 32'd7, 32'hFFFF_FFFE, 32'd1, 1'b0, 33);
    do_op("mulhu", OP, 3'b011, F7M, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 33);
    do_op("mul", OP, 3'b000, F7M, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 1'b0, 33);
    do_op("mul_neg", OP, 3'b000, F7M, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFA, 1'b0, 33);
    do_op("mulh", OP, 3'b001, F7M, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 1'b0, 33);
    do_op("mulhsu", OP, 3'b010, F7M, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 33);

    // Reset in the middle of an iterative op aborts it without output
    start_op(OP, 3'b100, F7M, 32'd100, 32'd7);
    repeat (5) @(negedge clk);
    check_eq("busy_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_busy_in_ready", 64'(in_ready), 64'd1);
    check_eq("rst_busy_out_valid", 64'(out_valid), 64'd0);
    seen_valid = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen_valid++;
    end
    check_eq("rst_busy_no_output", 64'(seen_valid), 64'd0);
`else
    do_op("muldiv_disabled", OP, 3'b000, F7M, 32'd6, 32'd7, 32'd0, 1'b1, 1);
    do_op("muldiv_disabled_div", OP, 3'b100, F7M, 32'd6, 32'd7, 32'd0, 1'b1, 1);

    // Reset while a result is pending drops it
    start_op(OP, 3'b000, F7B, 32'd1, 32'd2);
    wait_done(lat, rdy_seen);
    check_eq("pre_rst_out_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_done_in_ready", 64'(in_ready), 64'd1);
    check_eq("rst_done_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_done_result", 64'(result), 64'd0);
`endif

    // Unit still works after the late reset
    do_op("post_rst_add", OP, 3'b000, F7B, 32'd40, 32'd2, 32'd42, 1'b0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
